// File: rtl/cpu_bus_ram.sv
// cpu_bus_ram: tagged word RAM that responds on the CPU address/data bus.
// Each word holds 64 data bits and an 8-bit tag. An address strobe latches
// the word address, and later read and write strobes use that address.
// A side-band preload port lets an image loader fill the RAM directly.
module cpu_bus_ram #(
    parameter int AW      = 20,
    parameter bit AUTOINC = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   i_ad,
    input  logic [7:0]    i_tag,
    input  logic          i_astb,
    input  logic          i_rd,
    input  logic          i_wr,
    output logic [63:0]   o_data,
    output logic [7:0]    o_tag,
    output logic          o_valid,
    output logic          o_err,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [63:0]   i_ld_data,
    input  logic [7:0]    i_ld_tag,
    output logic          o_ld_ack
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        NOADDR   = 2'd0,
        ADDR_OK  = 2'd1,
        ADDR_BAD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          ld_ack_q, ld_ack_d;
    logic [63:0]   data_q;
    logic [7:0]    tag_q;

    logic [63:0]   mem     [DEPTH];
    logic [7:0]    tag_mem [DEPTH];

    logic          astb_s, wr_s, rd_s;
    logic          wr_acc, rd_acc, ld_acc;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_wtag;

    // Bus arbitration: the address strobe beats write, and write beats read.
    // The preload port gets the RAM write port only when the bus is not writing.
    always_comb begin
        astb_s    = !reset && i_astb;
        wr_s      = !reset && !i_astb && i_wr;
        rd_s      = !reset && !i_astb && !i_wr && i_rd;
        wr_acc    = wr_s && (state_q == ADDR_OK);
        rd_acc    = rd_s && (state_q == ADDR_OK);
        ld_acc    = !reset && i_ld_we && !wr_acc;
        mem_we    = wr_acc || ld_acc;
        mem_addr  = wr_acc ? waddr_q : i_ld_addr;
        mem_wdata = wr_acc ? i_ad : i_ld_data;
        mem_wtag  = wr_acc ? i_tag : i_ld_tag;
    end

    // Next-state logic for the address latch and the single-cycle status pulses.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        if (astb_s) begin
            waddr_d = i_ad[AW-1:0];
            state_d = (i_ad[63:AW] == '0) ? ADDR_OK : ADDR_BAD;
        end else if (AUTOINC && (wr_acc || rd_acc)) begin
            waddr_d = waddr_q + 1'b1;
        end
        valid_d  = rd_acc;
        err_d    = (wr_s || rd_s) && (state_q != ADDR_OK);
        ld_ack_d = ld_acc;
    end

    // Control registers: address state, latched word address, and the pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= NOADDR;
            waddr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ld_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ld_ack_q <= ld_ack_d;
        end
    end

    // Storage arrays: one shared write port for bus and preload; they are never cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            tag_mem[mem_addr] <= mem_wtag;
        end
    end

    // Registered read port: holds the last accepted read and clears on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            tag_q  <= '0;
        end else if (rd_acc) begin
            data_q <= mem[waddr_q];
            tag_q  <= tag_mem[waddr_q];
        end
    end

    assign o_data   = data_q;
    assign o_tag    = tag_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_ld_ack = ld_ack_q;

endmodule

// File: tb/tb_cpu_bus_ram.sv
// Testbench for cpu_bus_ram. It drives two instances from the same bus:
// u_dut0 holds the address between accesses, and u_dut1 auto-increments it.
module tb_cpu_bus_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb, i_rd, i_wr;
    logic        i_ld_we;
    logic [19:0] i_ld_addr;
    logic [63:0] i_ld_data;
    logic [7:0]  i_ld_tag;

    logic [63:0] o_data  [2];
    logic [7:0]  o_tag   [2];
    logic        o_valid [2];
    logic        o_err   [2];
    logic        o_ld_ack[2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_bus_ram #(.AW(20), .AUTOINC(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag),
        .i_astb(i_astb), .i_rd(i_rd), .i_wr(i_wr),
        .o_data(o_data[0]), .o_tag(o_tag[0]), .o_valid(o_valid[0]), .o_err(o_err[0]),
        .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_ld_tag(i_ld_tag), .o_ld_ack(o_ld_ack[0])
    );

    cpu_bus_ram #(.AW(20), .AUTOINC(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag),
        .i_astb(i_astb), .i_rd(i_rd), .i_wr(i_wr),
        .o_data(o_data[1]), .o_tag(o_tag[1]), .o_valid(o_valid[1]), .o_err(o_err[1]),
        .i_ld_we(i_ld_we), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_ld_tag(i_ld_tag), .o_ld_ack(o_ld_ack[1])
    );

    typedef struct {
        bit          rst, astb, wr, rd;
        logic [63:0] ad;
        logic [7:0]  tag;
        bit          ld_we;
        logic [19:0] ld_addr;
        logic [63:0] ld_data;
        logic [7:0]  ld_tag;
        bit          e_valid, e_err, e_ack;
        logic [63:0] e_data;
        logic [7:0]  e_tag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit astb, bit wr, bit rd,
                                logic [63:0] ad, logic [7:0] tag,
                                bit ld_we, logic [19:0] la, logic [63:0] ld, logic [7:0] lt,
                                bit ev, bit ee, bit ea, logic [63:0] ed, logic [7:0] et);
        vec_t v;
        v.rst = rst; v.astb = astb; v.wr = wr; v.rd = rd; v.ad = ad; v.tag = tag;
        v.ld_we = ld_we; v.ld_addr = la; v.ld_data = ld; v.ld_tag = lt;
        v.e_valid = ev; v.e_err = ee; v.e_ack = ea; v.e_data = ed; v.e_tag = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; i_astb = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
        i_ad = '0; i_tag = '0;
        i_ld_we = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_ld_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: word-addressed store keyed by instance, plus address state.
    logic [71:0] mm [int];
    int          m_state [2];
    int          m_waddr [2];
    logic [63:0] m_data  [2];
    logic [7:0]  m_tag   [2];
    bit          m_valid [2], m_err [2], m_ack [2], m_dk [2];

    task automatic model_step(input int k);
        bit wr_ok;
        int key;
        wr_ok = 1'b0;
        m_valid[k] = 1'b0; m_err[k] = 1'b0; m_ack[k] = 1'b0;
        if (reset) begin
            m_state[k] = 0; m_waddr[k] = 0; m_data[k] = '0; m_tag[k] = '0; m_dk[k] = 1'b1;
            return;
        end
        if (i_astb) begin
            m_waddr[k] = int'(i_ad[19:0]);
            m_state[k] = (i_ad[63:20] == 44'd0) ? 1 : 2;
        end else if (i_wr || i_rd) begin
            if (m_state[k] != 1) begin
                m_err[k] = 1'b1;
            end else begin
                key = k * 1048576 + m_waddr[k];
                if (i_wr) begin
                    mm[key] = {i_ad, i_tag};
                    wr_ok = 1'b1;
                end else begin
                    m_valid[k] = 1'b1;
                    if (mm.exists(key)) begin
                        {m_data[k], m_tag[k]} = mm[key];
                        m_dk[k] = 1'b1;
                    end else begin
                        m_dk[k] = 1'b0;
                    end
                end
                if (k == 1) m_waddr[k] = (m_waddr[k] + 1) % 1048576;
            end
        end
        if (i_ld_we && !wr_ok) begin
            mm[k * 1048576 + int'(i_ld_addr)] = {i_ld_data, i_ld_tag};
            m_ack[k] = 1'b1;
        end
    endtask

    task automatic model_cycle(input string nm);
        model_step(0);
        model_step(1);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_d%0d_valid", nm, k), 64'(o_valid[k]), 64'(m_valid[k]));
            chk($sformatf("%s_d%0d_err", nm, k), 64'(o_err[k]), 64'(m_err[k]));
            chk($sformatf("%s_d%0d_ack", nm, k), 64'(o_ld_ack[k]), 64'(m_ack[k]));
            if (m_dk[k]) begin
                chk($sformatf("%s_d%0d_data", nm, k), o_data[k], m_data[k]);
                chk($sformatf("%s_d%0d_tag", nm, k), 64'(o_tag[k]), 64'(m_tag[k]));
            end
        end
    endtask

    initial begin
        logic [63:0] va, vb, dd;
        int r;

        idle_inputs();

        // Directed vectors, checked on u_dut0 (address held between accesses).
        dd = 64'hDEADBEEF_01234567;
        //          rst astb wr rd  ad                 tag    ldwe la        ld        lt     ev ee ea data      etag
        tbl.push_back(mk(1, 0, 0, 0, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, 64'h0,    8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 1, 0, 64'h0,    8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 64'h10,          8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, 64'h0,    8'h00));
        tbl.push_back(mk(0, 0, 1, 0, dd,              8'h5A, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, 64'h0,    8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 1, 0, 0, dd,       8'h5A));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 64'h0,       8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 1, 0, 0, 64'h100000,      8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 1, 0, 64'h55,          8'h11, 1, 20'h21,  64'h2222, 8'h09, 0, 1, 1, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 1, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 1, 0, 0, 64'h10,          8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 1, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 1, 0, 64'hABCD,        8'h33, 1, 20'h20,  64'h1111, 8'h07, 0, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 0, 0, 64'h0,           8'h00, 1, 20'h20,  64'h1111, 8'h07, 0, 0, 1, dd,       8'h5A));
        tbl.push_back(mk(0, 1, 0, 0, 64'h20,          8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, dd,       8'h5A));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 1, 0, 0, 64'h1111, 8'h07));
        tbl.push_back(mk(0, 1, 1, 1, 64'h10,          8'hFF, 0, 20'h0,   64'h0,    8'h00, 0, 0, 0, 64'h1111, 8'h07));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 1, 0, 0, 64'hABCD, 8'h33));
        tbl.push_back(mk(1, 1, 0, 0, 64'h10,          8'h00, 1, 20'h30,  64'h3333, 8'h01, 0, 0, 0, 64'h0,    8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0,           8'h00, 0, 20'h0,   64'h0,    8'h00, 0, 1, 0, 64'h0,    8'h00));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; i_astb = tbl[i].astb; i_wr = tbl[i].wr; i_rd = tbl[i].rd;
            i_ad = tbl[i].ad; i_tag = tbl[i].tag;
            i_ld_we = tbl[i].ld_we; i_ld_addr = tbl[i].ld_addr;
            i_ld_data = tbl[i].ld_data; i_ld_tag = tbl[i].ld_tag;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(o_valid[0]), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d_err", i), 64'(o_err[0]), 64'(tbl[i].e_err));
            chk($sformatf("vec%0d_ack", i), 64'(o_ld_ack[0]), 64'(tbl[i].e_ack));
            chk($sformatf("vec%0d_data", i), o_data[0], tbl[i].e_data);
            chk($sformatf("vec%0d_tag", i), 64'(o_tag[0]), 64'(tbl[i].e_tag));
        end
        idle_inputs();

        // Burst across the top of the address space; u_dut0 overwrites one word.
        va = 64'hAAAA_0000_1234_5678;
        vb = 64'hBBBB_0000_8765_4321;
        i_astb = 1'b1; i_ad = 64'hFFFFF; tick();
        idle_inputs(); i_wr = 1'b1; i_ad = va; i_tag = 8'hA1; tick();
        chk("burst_wr1_err", 64'(o_err[1]), 64'd0);
        idle_inputs(); i_wr = 1'b1; i_ad = vb; i_tag = 8'hB2; tick();
        chk("burst_wr2_err", 64'(o_err[1]), 64'd0);
        idle_inputs(); i_astb = 1'b1; i_ad = 64'hFFFFF; tick();
        idle_inputs(); i_rd = 1'b1; tick();
        chk("burst_rd1_valid", 64'(o_valid[1]), 64'd1);
        chk("burst_rd1_data", o_data[1], va);
        chk("burst_rd1_tag", 64'(o_tag[1]), 64'h00A1);
        chk("held_rd1_data", o_data[0], vb);
        tick();
        chk("burst_rd2_valid", 64'(o_valid[1]), 64'd1);
        chk("burst_rd2_data", o_data[1], vb);
        chk("burst_rd2_tag", 64'(o_tag[1]), 64'h00B2);
        chk("held_rd2_data", o_data[0], vb);
        chk("held_rd2_tag", 64'(o_tag[0]), 64'h00B2);
        idle_inputs(); tick();

        // Randomized traffic against the model, both instances.
        reset = 1'b1;
        model_cycle("rst");
        idle_inputs();
        for (int a = 0; a < 80; a++) begin
            i_ld_we = 1'b1;
            i_ld_addr = (a < 64) ? 20'(a) : 20'(32'hFFFF0 + 32'(a - 64));
            i_ld_data = {$urandom, $urandom};
            i_ld_tag = 8'($urandom);
            model_cycle("pre");
        end
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) < 2);
            i_astb = ($urandom_range(0, 3) == 0);
            i_wr = ($urandom_range(0, 3) == 0);
            i_rd = ($urandom_range(0, 2) == 0);
            i_tag = 8'($urandom);
            if (i_astb) begin
                r = $urandom_range(0, 9);
                if (r < 6) i_ad = 64'($urandom_range(0, 15));
                else if (r < 8) i_ad = 64'(32'hFFFF0 + $urandom_range(0, 15));
                else i_ad = 64'($urandom_range(0, 15)) | (64'd1 << $urandom_range(20, 63));
            end else begin
                i_ad = {$urandom, $urandom};
            end
            i_ld_we = ($urandom_range(0, 4) == 0);
            i_ld_addr = 20'($urandom_range(0, 63));
            i_ld_data = {$urandom, $urandom};
            i_ld_tag = 8'($urandom);
            model_cycle("rnd");
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ram.md
Name: cpu_bus_ram

Overview:
Synthesizable responder (memory end) of the CPU address/data bus: a tagged word RAM, 64-bit data plus 8-bit tag per word. Latches a word address on the address strobe, then services write and read strobes against that address. Replaces the behavioural RAM in the CPU testbench and is the memory target for FPGA builds. Adds range checking, optional burst auto-increment and a side-band preload port for image loading.

Parameters:
AW, 20, word-address width; depth = 2**AW words.
AUTOINC, 0, 1 = latched address increments after every accepted rd/wr (burst mode); 0 = address held.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
i_ad  input  64  address (with i_astb) or write data (with i_wr), driven by CPU o_ad
i_tag  input  8  write tag, driven by CPU o_tag
i_astb  input  1  address strobe
i_rd  input  1  read request
i_wr  input  1  write request
o_data  output  64  read data, to CPU i_data
o_tag  output  8  read tag, to CPU i_tag
o_valid  output  1  one-cycle pulse: o_data/o_tag updated by a read
o_err  output  1  one-cycle pulse: rd/wr rejected
i_ld_we  input  1  preload write enable
i_ld_addr  input  AW  preload word address
i_ld_data  input  64  preload data
i_ld_tag  input  8  preload tag
o_ld_ack  output  1  one-cycle pulse: preload write performed

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset: o_data=0, o_tag=0, o_valid=0, o_err=0, o_ld_ack=0, waddr=0, state=NOADDR. RAM and tag array are not cleared. Strobes sampled in a reset cycle are ignored.
- States: NOADDR (no address latched since reset), ADDR_OK (in range), ADDR_BAD (i_ad[63:AW] nonzero at strobe).
- Bus priority in one cycle: i_astb > i_wr > i_rd; lower-priority strobes in the same cycle are dropped silently, with no err.
- i_astb: waddr <= i_ad[AW-1:0]. Next state is ADDR_OK if i_ad[63:AW]==0, else ADDR_BAD. Legal from any state.
- i_wr in ADDR_OK: mem[waddr] <= i_ad and tag[waddr] <= i_tag at that edge. o_err stays 0.
- i_rd in ADDR_OK: o_data <= mem[waddr] and o_tag <= tag[waddr] at that edge; o_valid=1 for the following cycle. Latency: data visible the cycle after i_rd.
- o_data/o_tag hold their last read value until the next accepted read. A rejected read does not change them.
- Read after write to the same address in consecutive cycles returns the new value. A same-cycle conflict cannot occur because wr outranks rd.
- i_rd or i_wr in NOADDR or ADDR_BAD: no RAM change, o_err=1 next cycle, o_valid=0.
- AUTOINC=1: after each accepted rd/wr, waddr <= waddr+1 modulo 2**AW. Wrap 2**AW-1 -> 0 stays ADDR_OK. AUTOINC=0: waddr unchanged.
- Preload: i_ld_we writes mem/tag[i_ld_addr] when no accepted i_wr occurs that cycle; o_ld_ack=1 next cycle. Blocked by i_wr: no write, no ack, and the loader retries. Preload does not affect waddr or state. Preload in a reset cycle is ignored.
- o_valid, o_err and o_ld_ack are single-cycle pulses; o_valid and o_err are never both high.

Test Plan:
- Reset, then i_rd with no prior astb -> o_err pulse, o_valid=0, o_data=0.
- astb 0x00010, wr 0xDEADBEEF_01234567 tag 0x5A, rd -> next cycle o_data=0xDEADBEEF_01234567, o_tag=0x5A, o_valid=1; data held for 5 idle cycles.
- astb 0x100000 with AW=20 -> ADDR_BAD; wr then rd -> two o_err pulses; astb 0x00010 then rd still returns the earlier value.
- AUTOINC=1: astb 0xFFFFF, wr A, wr B -> mem[0xFFFFF]=A, mem[0]=B; astb 0xFFFFF, rd, rd -> A then B.
- Preload addr 0x00020 = 0x1111 tag 0x07 with concurrent i_wr -> no ack; retry idle -> o_ld_ack; bus read of 0x00020 -> 0x1111/0x07.
- astb, wr and rd asserted together -> only the address is latched; reset asserted mid-burst -> outputs 0, state NOADDR, next rd gives o_err.
